// File: rtl/rf_write_tracer.sv
// Register-file write tracer: time-stamps qualifying register-file writes into a trace FIFO
// and raises halt_req on a watch match or a cycle timeout. Optional macro: TRACE_CHANGE_ONLY_EN.
module rf_write_tracer #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int DEPTH   = 16,
  parameter int TSW     = 32,
  parameter int TIMEOUT = 0,
  parameter int IGN_R0  = 1,
  localparam int NREGS  = 2**AW,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf_we,
  input  logic [AW-1:0]    rf_wa,
  input  logic [DW-1:0]    rf_wd,
  input  logic [NREGS-1:0] trace_mask,
  input  logic             match_en,
  input  logic [AW-1:0]    match_addr,
  input  logic [DW-1:0]    match_data,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [AW-1:0]    trc_addr,
  output logic [DW-1:0]    trc_data,
  output logic [TSW-1:0]   trc_stamp,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic             match_hit,
  output logic             timeout,
  output logic             halt_req
);
  localparam int IW = $clog2(DEPTH);

  // Trace port handshake: the head entry transfers on any edge where trc_valid & trc_ready;
  // while trc_valid is high and trc_ready is low, the head outputs hold stable.

  logic [CW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]  r_mem_addr  [DEPTH];
  logic [DW-1:0]  r_mem_data  [DEPTH];
  logic [TSW-1:0] r_mem_stamp [DEPTH];
  logic [TSW-1:0] r_stamp;
  logic           r_overflow;
  logic [15:0]    r_drop_cnt;
  logic           r_match_hit;
  logic           r_timeout;

  logic          w_halt, w_r0, w_changed, w_qual, w_full, w_valid;
  logic          w_pop, w_push, w_drop, w_match, w_tmo_hit;
  logic [CW-1:0] w_count;
  logic [IW-1:0] w_wr_idx, w_rd_idx;

  assign w_halt   = r_match_hit | r_timeout;
  assign w_r0     = (IGN_R0 != 0) && (rf_wa == '0);
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == CW'(DEPTH));
  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid & trc_ready;
  assign w_qual   = rf_we & trace_mask[rf_wa] & ~w_r0 & ~w_halt & w_changed;
  assign w_push   = w_qual & (~w_full | w_pop);
  assign w_drop   = w_qual & w_full & ~w_pop;
  assign w_match  = match_en & rf_we & (rf_wa == match_addr) & (rf_wd == match_data) & ~w_r0;
  assign w_wr_idx = r_wr_ptr[IW-1:0];
  assign w_rd_idx = r_rd_ptr[IW-1:0];

`ifdef TRACE_CHANGE_ONLY_EN
  // Shadow tracks every write, even while frozen, so change detection stays accurate.
  logic [DW-1:0] r_shadow [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_shadow[i] <= '0;
    end else if (rf_we) begin
      r_shadow[rf_wa] <= rf_wd;
    end
  end

  assign w_changed = (rf_wd != r_shadow[rf_wa]);
`else
  assign w_changed = 1'b1;
`endif

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int TCW = $clog2(TIMEOUT + 1);
      logic [TCW-1:0] r_tcnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tcnt <= '0;
        end else if (r_tcnt != TCW'(TIMEOUT)) begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end

      assign w_tmo_hit = (r_tcnt == TCW'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_stamp     <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_match_hit <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_match)   r_match_hit <= 1'b1;
      if (w_tmo_hit) r_timeout   <= 1'b1;
    end
  end

  // Storage needs no reset: head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[w_wr_idx]  <= rf_wa;
      r_mem_data[w_wr_idx]  <= rf_wd;
      r_mem_stamp[w_wr_idx] <= r_stamp;
    end
  end

  assign trc_valid = w_valid;
  assign trc_addr  = w_valid ? r_mem_addr[w_rd_idx]  : '0;
  assign trc_data  = w_valid ? r_mem_data[w_rd_idx]  : '0;
  assign trc_stamp = w_valid ? r_mem_stamp[w_rd_idx] : '0;
  assign count     = w_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign match_hit = r_match_hit;
  assign timeout   = r_timeout;
  assign halt_req  = w_halt;

endmodule

// File: tb/tb_rf_write_tracer.sv
// Bench for rf_write_tracer: directed scenarios plus randomized traffic against a queue-based
// model of the trace FIFO, drop accounting, watch match and timeout freeze.
module tb_rf_write_tracer;
  localparam int DW = 8, AW = 3, DEPTH = 4, TSW = 16, TIMEOUT = 100, IGN_R0 = 1;
  localparam int NREGS = 2**AW, CW = $clog2(DEPTH) + 1, EW = TSW + AW + DW;
`ifdef TRACE_CHANGE_ONLY_EN
  localparam int EXP_REPEAT = 1;
`else
  localparam int EXP_REPEAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, rf_we, match_en, trc_ready;
  logic [AW-1:0]    rf_wa, match_addr;
  logic [DW-1:0]    rf_wd, match_data;
  logic [NREGS-1:0] trace_mask;
  logic             trc_valid, overflow, match_hit, timeout, halt_req;
  logic [AW-1:0]    trc_addr;
  logic [DW-1:0]    trc_data;
  logic [TSW-1:0]   trc_stamp;
  logic [CW-1:0]    count;
  logic [15:0]      drop_cnt;

  rf_write_tracer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TSW(TSW), .TIMEOUT(TIMEOUT), .IGN_R0(IGN_R0)) dut (
    .clk(clk), .reset(reset), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .trace_mask(trace_mask), .match_en(match_en), .match_addr(match_addr), .match_data(match_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_addr(trc_addr), .trc_data(trc_data),
    .trc_stamp(trc_stamp), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .match_hit(match_hit), .timeout(timeout), .halt_req(halt_req)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as {stamp, addr, data}, plus flags and cycle count since release.
  logic [EW-1:0]  exp_q[$];
  logic [TSW-1:0] m_stamp;
  int             m_edges, m_drops;
  bit             m_ovf, m_match, m_tmo;
  logic [DW-1:0]  m_shadow [NREGS];

  task automatic model_reset();
    exp_q.delete();
    m_stamp = '0; m_edges = 0; m_drops = 0;
    m_ovf = 0; m_match = 0; m_tmo = 0;
    for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
  endtask

  // Drives one cycle of inputs, advances the model, clocks, and returns #1 after the edge.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rdy);
    bit chg, qual, full, pop;
    rf_we = we; rf_wa = wa; rf_wd = wd; trc_ready = rdy;
    chg = 1;
`ifdef TRACE_CHANGE_ONLY_EN
    chg = (wd != m_shadow[wa]);
    if (we) m_shadow[wa] = wd;
`endif
    qual = we && trace_mask[wa] && !(IGN_R0 != 0 && wa == 0) && !(m_match || m_tmo) && chg;
    full = (exp_q.size() == DEPTH);
    pop  = rdy && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (qual) begin
      if (!full || pop) exp_q.push_back({m_stamp, wa, wd});
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (match_en && we && wa == match_addr && wd == match_data && !(IGN_R0 != 0 && wa == 0)) m_match = 1;
    if (m_edges == TIMEOUT - 1) m_tmo = 1;
    m_edges++;
    m_stamp++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; rf_we = 0; rf_wa = '0; rf_wd = '0; trc_ready = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    trace_mask = '1; match_en = 1; match_addr = 3'd2; match_data = 8'h44;
    drive(1, 3'd1, 8'h12, 0);
    drive(1, 3'd2, 8'h44, 0);
    drive(0, '0, '0, 0);
    reset = 1'b0;
    #2;
    checks++;
    if ({trc_valid, count, overflow, drop_cnt, match_hit, timeout, halt_req, trc_addr, trc_data, trc_stamp} !== '0) begin
      errors++;
      $display("FAIL reset_async got v=%0b cnt=%0d mh=%0b hr=%0b exp all zero", trc_valid, count, match_hit, halt_req);
    end
    @(posedge clk); #1;
    checks++;
    if ({trc_valid, count, overflow, drop_cnt, match_hit, timeout, halt_req} !== '0) begin
      errors++;
      $display("FAIL reset_held got v=%0b cnt=%0d ovf=%0b exp all zero", trc_valid, count, overflow);
    end
    reset = 1'b1;
    model_reset();
    match_en = 0;
  endtask

  task automatic test_basic();
    do_reset();
    trace_mask = '1; match_en = 0;
    repeat (3) drive(0, '0, '0, 0);
    drive(1, 3'd1, 8'd5, 0);
    drive(1, 3'd2, 8'd7, 0);
    checks++;
    if (count !== CW'(2)) begin errors++; $display("FAIL basic_count2 got %0d exp 2", count); end
    drive(0, '0, '0, 0);
    checks++;
    if ({trc_valid, trc_stamp, trc_addr, trc_data} !== {1'b1, 16'd3, 3'd1, 8'd5}) begin
      errors++; $display("FAIL basic_head1 got v=%0b s=%0d a=%0d d=%0d exp 1/3/1/5", trc_valid, trc_stamp, trc_addr, trc_data);
    end
    drive(0, '0, '0, 1);
    checks++;
    if ({trc_valid, trc_stamp, trc_addr, trc_data, count} !== {1'b1, 16'd4, 3'd2, 8'd7, 3'd1}) begin
      errors++; $display("FAIL basic_head2 got v=%0b s=%0d a=%0d d=%0d c=%0d exp 1/4/2/7/1", trc_valid, trc_stamp, trc_addr, trc_data, count);
    end
    drive(0, '0, '0, 1);
    checks++;
    if ({trc_valid, count} !== 4'b0) begin errors++; $display("FAIL basic_empty got v=%0b c=%0d exp 0/0", trc_valid, count); end
  endtask

  task automatic test_overflow();
    do_reset();
    trace_mask = '1;
    for (int i = 1; i <= 6; i++) drive(1, AW'(i), DW'(8'h10 + i), 0);
    checks++;
    if ({count, overflow, drop_cnt} !== {3'd4, 1'b1, 16'd2}) begin
      errors++; $display("FAIL ovf_state got c=%0d o=%0b dc=%0d exp 4/1/2", count, overflow, drop_cnt);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({trc_valid, trc_stamp, trc_addr, trc_data} !== {1'b1, 16'(i - 1), AW'(i), DW'(8'h10 + i)}) begin
        errors++; $display("FAIL ovf_drain%0d got s=%0d a=%0d d=%0h exp %0d/%0d/%0h", i, trc_stamp, trc_addr, trc_data, i - 1, i, 8'h10 + i);
      end
      drive(0, '0, '0, 1);
    end
    checks++;
    if ({count, overflow} !== {3'd0, 1'b1}) begin errors++; $display("FAIL ovf_after got c=%0d o=%0b exp 0/1", count, overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    trace_mask = '1;
    for (int i = 1; i <= 4; i++) drive(1, AW'(i), DW'(8'h20 + i), 0);
    drive(1, 3'd5, 8'h99, 1);
    checks++;
    if ({count, overflow, drop_cnt} !== {3'd4, 1'b0, 16'd0}) begin
      errors++; $display("FAIL fullpop_state got c=%0d o=%0b dc=%0d exp 4/0/0", count, overflow, drop_cnt);
    end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if ({trc_stamp, trc_addr} !== {16'(i - 1), AW'(i)}) begin
        errors++; $display("FAIL fullpop_drain%0d got s=%0d a=%0d exp %0d/%0d", i, trc_stamp, trc_addr, i - 1, i);
      end
      drive(0, '0, '0, 1);
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL fullpop_empty got %0d exp 0", count); end
  endtask

  task automatic test_ignore();
    do_reset();
    trace_mask = 8'hF7;
    drive(1, 3'd0, 8'h11, 0);
    drive(1, 3'd3, 8'h22, 0);
    drive(1, 3'd4, 8'h33, 0);
    checks++;
    if ({count, trc_stamp, trc_addr, trc_data} !== {3'd1, 16'd2, 3'd4, 8'h33}) begin
      errors++; $display("FAIL ignore got c=%0d s=%0d a=%0d d=%0h exp 1/2/4/33", count, trc_stamp, trc_addr, trc_data);
    end
  endtask

  task automatic test_match();
    do_reset();
    trace_mask = '1; match_en = 1; match_addr = 3'd2; match_data = 8'h37;
    drive(1, 3'd2, 8'h36, 0);
    checks++;
    if (match_hit !== 1'b0) begin errors++; $display("FAIL match_early got %0b exp 0", match_hit); end
    drive(1, 3'd2, 8'h37, 0);
    checks++;
    if ({match_hit, halt_req, count} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL match_hit got mh=%0b hr=%0b c=%0d exp 1/1/2", match_hit, halt_req, count);
    end
    drive(1, 3'd1, 8'h55, 0);
    checks++;
    if ({count, drop_cnt} !== {3'd2, 16'd0}) begin errors++; $display("FAIL match_freeze got c=%0d dc=%0d exp 2/0", count, drop_cnt); end
    drive(0, '0, '0, 1);
    checks++;
    if ({trc_stamp, trc_addr, trc_data} !== {16'd1, 3'd2, 8'h37}) begin
      errors++; $display("FAIL match_entry got s=%0d a=%0d d=%0h exp 1/2/37", trc_stamp, trc_addr, trc_data);
    end
    drive(0, '0, '0, 1);
    checks++;
    if ({count, halt_req} !== {3'd0, 1'b1}) begin errors++; $display("FAIL match_sticky got c=%0d hr=%0b exp 0/1", count, halt_req); end
    match_en = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    trace_mask = '1;
    repeat (TIMEOUT - 1) drive(0, '0, '0, 0);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b exp 0", timeout); end
    drive(0, '0, '0, 0);
    checks++;
    if ({timeout, halt_req} !== 2'b11) begin errors++; $display("FAIL tmo_rise got t=%0b hr=%0b exp 1/1", timeout, halt_req); end
    drive(1, 3'd1, 8'd5, 0);
    checks++;
    if ({count, drop_cnt} !== {3'd0, 16'd0}) begin errors++; $display("FAIL tmo_freeze got c=%0d dc=%0d exp 0/0", count, drop_cnt); end
    reset = 1'b0;
    #1;
    checks++;
    if ({timeout, halt_req, count} !== '0) begin errors++; $display("FAIL tmo_reset got t=%0b hr=%0b exp 0/0", timeout, halt_req); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (TIMEOUT / 2) drive(0, '0, '0, 0);
    do_reset();
    repeat (TIMEOUT - 1) drive(0, '0, '0, 0);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_restart_early got %0b exp 0", timeout); end
    drive(0, '0, '0, 0);
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_restart got %0b exp 1", timeout); end
  endtask

  task automatic test_change_only();
    do_reset();
    trace_mask = '1;
    drive(1, 3'd1, 8'd5, 0);
    drive(1, 3'd1, 8'd5, 0);
    drive(0, '0, '0, 0);
    checks++;
    if (count !== CW'(EXP_REPEAT)) begin errors++; $display("FAIL change_only got %0d exp %0d", count, EXP_REPEAT); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      trace_mask = NREGS'($urandom);
      match_en   = 1'($urandom_range(0, 1));
      match_addr = AW'($urandom_range(1, NREGS - 1));
      match_data = DW'($urandom_range(0, 3));
      for (int c = 0; c < 130; c++) begin
        checks++;
        if (trc_valid !== (exp_q.size() > 0)) begin
          errors++; $display("FAIL rnd_valid r%0d c%0d got %0b exp %0b", r, c, trc_valid, exp_q.size() > 0);
        end else if (exp_q.size() > 0) begin
          checks++;
          if ({trc_stamp, trc_addr, trc_data} !== exp_q[0]) begin
            errors++; $display("FAIL rnd_head r%0d c%0d got %0h exp %0h", r, c, {trc_stamp, trc_addr, trc_data}, exp_q[0]);
          end
        end
        checks++;
        if ({count, overflow, drop_cnt} !== {CW'(exp_q.size()), m_ovf, 16'(m_drops)}) begin
          errors++; $display("FAIL rnd_count r%0d c%0d got c=%0d o=%0b dc=%0d exp %0d/%0b/%0d", r, c, count, overflow, drop_cnt, exp_q.size(), m_ovf, m_drops);
        end
        checks++;
        if ({match_hit, timeout, halt_req} !== {m_match, m_tmo, m_match | m_tmo}) begin
          errors++; $display("FAIL rnd_flags r%0d c%0d got mh=%0b t=%0b hr=%0b exp %0b/%0b", r, c, match_hit, timeout, halt_req, m_match, m_tmo);
        end
        drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NREGS - 1)),
              DW'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
      end
    end
  endtask

  initial begin
    reset = 1'b0; rf_we = 0; rf_wa = '0; rf_wd = '0; trc_ready = 0;
    trace_mask = '0; match_en = 0; match_addr = '0; match_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_ignore();
    test_match();
    test_timeout();
    test_change_only();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
